// File: rtl/heart_pulse_timer.sv
// Heartbeat interval timer: measures the time between PULSE rising edges in prescaled ticks and reports it on PERIOD/STATUS.
// Define HPT_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES-sample level filter ahead of the edge detector.
module heart_pulse_timer #(
    parameter int PRESCALE        = 500000,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PULSE,
    input  logic       ACK,
    output logic [7:0] PERIOD,
    output logic [7:0] STATUS
);

    localparam int              PW         = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]      CNT_MAX    = 8'hFF;

    if (PRESCALE < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("heart_pulse_timer: PRESCALE must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    // Input conditioning
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic lvl_prev_q, lvl_prev_d;
    logic ack_prev_q, ack_prev_d;
    logic lvl;
    logic pulse_edge;
    logic ack_edge;

    always_comb begin
        sync1_d    = PULSE;
        sync2_d    = sync1_q;
        lvl_prev_d = lvl;
        ack_prev_d = ACK;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_prev_q <= lvl_prev_d;
            ack_prev_q <= ack_prev_d;
        end
    end

`ifdef HPT_DEBOUNCE_EN
    localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          filt_q, filt_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;

    // The filtered level follows sync2 only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (db_cnt_q == DB_LAST) begin
                filt_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            filt_q   <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    assign pulse_edge = lvl & ~lvl_prev_q;
    assign ack_edge   = ACK & ~ack_prev_q;

    // Measurement datapath and controller
    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      cnt_inc;
    logic [7:0]      period_q, period_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            sat_q, sat_d;
    logic            tick;

    assign tick = (presc_q == PRESC_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        // A tick landing on the capturing edge still counts, so N*PRESCALE cycles read as N.
        cnt_inc = cnt_q;
        if (tick && cnt_q != CNT_MAX) begin
            cnt_inc = cnt_q + 8'd1;
        end

        state_d   = state_q;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        cnt_d     = cnt_inc;
        period_d  = period_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        sat_d     = sat_q;

        if (ack_edge) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                cnt_d   = '0;
                if (pulse_edge) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (pulse_edge) begin
                    period_d  = cnt_inc;
                    sat_d     = (cnt_inc == CNT_MAX);
                    valid_d   = 1'b1;
                    overrun_d = valid_q & ~ack_edge;
                    presc_d   = '0;
                    cnt_d     = '0;
                end else if (tick && cnt_q == CNT_MAX) begin
                    // No beat within 256 ticks: give up and wait for a fresh start edge.
                    state_d = ST_IDLE;
                    sat_d   = 1'b1;
                    presc_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            sat_q     <= sat_d;
        end
    end

    assign PERIOD = period_q;
    assign STATUS = {4'b0000, (state_q == ST_MEASURE), sat_q, overrun_q, valid_q};

endmodule

// File: tb/tb_heart_pulse_timer.sv
// Directed bench for heart_pulse_timer: table-driven capture/handshake vectors plus saturation, timeout and reset sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_heart_pulse_timer;

`ifdef HPT_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    // Step (after the PULSE rise drive) at which a capture first becomes visible.
    localparam int LAT = 3 + DB;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b0;
    logic       PULSE = 1'b0;
    logic       ACK   = 1'b0;
    logic [7:0] period4, status4;
    logic [7:0] period2, status2;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    heart_pulse_timer #(.PRESCALE(4), .DEBOUNCE_CYCLES(4)) dut4 (
        .CLK    (CLK),
        .RESET  (RESET),
        .PULSE  (PULSE),
        .ACK    (ACK),
        .PERIOD (period4),
        .STATUS (status4)
    );

    heart_pulse_timer #(.PRESCALE(2), .DEBOUNCE_CYCLES(4)) dut2 (
        .CLK    (CLK),
        .RESET  (RESET),
        .PULSE  (PULSE),
        .ACK    (ACK),
        .PERIOD (period2),
        .STATUS (status2)
    );

    typedef struct {
        int         gap;       // cycles from this PULSE rise to the next one
        logic       ack_pre;   // ACK level driven the cycle before the capture
        logic       ack_post;  // ACK level driven at step 10
        logic [7:0] period;    // PERIOD right after this edge
        logic [7:0] status;    // STATUS right after this edge
        logic [7:0] late;      // STATUS at the end of the interval
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Steps 'first'..'first+n-1' of a beat: PULSE is high for steps 0..5.
    task automatic beat_steps(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            PULSE = (i < 6);
            step();
        end
    endtask

    task automatic do_reset(input string tag);
        RESET = 1'b1;
        ACK   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            PULSE = i[0];
            step();
            check($sformatf("%s rst%0d period4", tag, i), period4, 8'h00);
            check($sformatf("%s rst%0d status4", tag, i), status4, 8'h00);
            check($sformatf("%s rst%0d status2", tag, i), status2, 8'h00);
        end
        RESET = 1'b0;
        PULSE = 1'b0;
        step();
        check($sformatf("%s post period4", tag), period4, 8'h00);
        check($sformatf("%s post status4", tag), status4, 8'h00);
        check($sformatf("%s post period2", tag), period2, 8'h00);
        check($sformatf("%s post status2", tag), status2, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev_late;

        // PRESCALE=4: 40 cycles = 10 ticks, 20 = 5, 13 = 3.
        vecs[0] = '{40, 1'b0, 1'b0, 8'd0,  8'h08, 8'h08};  // start edge, no capture
        vecs[1] = '{40, 1'b0, 1'b0, 8'd10, 8'h09, 8'h09};  // first capture
        vecs[2] = '{40, 1'b0, 1'b1, 8'd10, 8'h0B, 8'h08};  // overrun, then ACK rise clears
        vecs[3] = '{40, 1'b1, 1'b1, 8'd10, 8'h09, 8'h09};  // ACK held high: no further clear
        vecs[4] = '{40, 1'b0, 1'b0, 8'd10, 8'h0B, 8'h0B};  // ACK falling has no effect
        vecs[5] = '{20, 1'b1, 1'b1, 8'd10, 8'h09, 8'h09};  // ACK rise with capture: edge wins
        vecs[6] = '{40, 1'b0, 1'b0, 8'd5,  8'h0B, 8'h0B};
        vecs[7] = '{13, 1'b0, 1'b0, 8'd10, 8'h0B, 8'h0B};
        vecs[8] = '{40, 1'b0, 1'b0, 8'd3,  8'h0B, 8'h0B};

        do_reset("init");

        prev_late = 8'h00;
        for (int r = 0; r < 9; r++) begin
            for (int i = 0; i < vecs[r].gap; i++) begin
                if (i == LAT - 1) begin
                    check($sformatf("v%0d pre status", r), status4, prev_late);
                    ACK = vecs[r].ack_pre;
                end
                if (i == LAT) begin
                    check($sformatf("v%0d period", r), period4, vecs[r].period);
                    check($sformatf("v%0d status", r), status4, vecs[r].status);
                end
                if (i == 10) ACK = vecs[r].ack_post;
                if (i == vecs[r].gap - 1) check($sformatf("v%0d late status", r), status4, vecs[r].late);
                PULSE = (i < 6);
                step();
            end
            prev_late = vecs[r].late;
        end

        // Reset with a completed capture and a partial interval pending.
        do_reset("mid");

        // PRESCALE=2: 511-cycle interval saturates, then timeout 512 cycles after capture.
        beat_steps(0, LAT);
        check("sat start period2", period2, 8'd0);
        check("sat start status2", status2, 8'h08);
        beat_steps(LAT, 511 - LAT);
        beat_steps(0, LAT);
        check("sat period2", period2, 8'd255);
        check("sat status2", status2, 8'h0D);
        beat_steps(LAT, 511);
        check("pre-timeout status2", status2, 8'h0D);
        beat_steps(LAT + 511, 1);
        check("timeout status2", status2, 8'h05);
        check("timeout period2", period2, 8'd255);
        beat_steps(LAT + 512, 80);
        check("idle status2", status2, 8'h05);
        beat_steps(0, LAT);
        check("restart period2", period2, 8'd255);
        check("restart status2", status2, 8'h0D);
        beat_steps(LAT, 40 - LAT);
        beat_steps(0, LAT);
        check("in-range period2", period2, 8'd20);
        check("in-range status2", status2, 8'h0B);
        beat_steps(LAT, 20);

`ifdef HPT_DEBOUNCE_EN
        do_reset("db");
        for (int i = 0; i < 16; i++) begin
            PULSE = (i < 3);
            step();
        end
        check("glitch status4", status4, 8'h00);
        check("glitch status2", status2, 8'h00);
        for (int i = 0; i < 20; i++) begin
            if (i == LAT - 1) check("db pre status4", status4, 8'h00);
            if (i == LAT) check("db edge status4", status4, 8'h08);
            PULSE = (i < 10);
            step();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/heart_pulse_timer.md
Name: heart_pulse_timer

Overview:
- Upstream input stage for the heart-rate monitor datapath.
- Measures the interval between heartbeat pulses in prescaled ticks and presents the result to the processor's memory-mapped input ports.
- PERIOD drives IOA (addr 249); STATUS drives IOB (addr 250); ACK is driven by IOD[0] (addr 252). Software reads PERIOD and converts it to BPM using the BCD LUT in data memory.

Parameters:
- PRESCALE, 500000, CLK cycles per interval tick (>=2).
- DEBOUNCE_CYCLES, 16, consecutive stable samples required by the optional filter (>=1).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- PULSE  input  1  asynchronous heartbeat pulse from sensor comparator.
- ACK  input  1  software acknowledge; rising edge clears VALID (from IOD[0]).
- PERIOD  output  8  last measured interval in ticks, saturating.
- STATUS  output  8  bit0 VALID, bit1 OVERRUN, bit2 SAT, bit3 RUN, bits7:4 = 0.

Behaviour:
- Reset (RESET=1 at a CLK edge): PERIOD=0, STATUS=0, state=IDLE, prescaler=0, interval count=0. Synchronizer, edge-detect and ACK history flops = 0. Reset mid-measurement discards the partial interval.
- Input conditioning:
  - PULSE passes through a 2-flop synchronizer, then rising-edge detect (sync2 & ~prev) -> EDGE, one cycle wide.
  - ACK is used directly (it is synchronous, from a register); rising-edge detect -> ACKE.
- Tick generator: prescaler counts 0..PRESCALE-1 and asserts TICK for one cycle on the wrap. It is forced to 0 on every EDGE, so each interval starts aligned.
- Interval counter: 8 bits, +1 on TICK, saturates at 255. When it reaches 255, internal sat flag = 1. Counter is cleared on EDGE.
- State machine:
  - IDLE: RUN=0. On EDGE -> MEASURE; clear counter and prescaler. No PERIOD update.
  - MEASURE: RUN=1. On EDGE: PERIOD <= counter value (pre-clear); SAT <= sat flag; VALID <= 1; OVERRUN <= 1 if VALID was already 1 and not cleared this cycle; then clear counter and prescaler. Remain in MEASURE.
  - MEASURE timeout: when counter = 255 and TICK occurs again -> IDLE (no beat). SAT=1, VALID unchanged, PERIOD unchanged.
- ACKE clears VALID and OVERRUN. If ACKE and a PERIOD-latching EDGE occur in the same cycle, the edge wins: VALID=1, OVERRUN=0, new PERIOD.
- SAT is cleared only by a subsequent in-range capture or by RESET.
- Latency: PULSE high before CLK edge k -> EDGE at edge k+2 -> PERIOD/VALID updated and visible after edge k+2. STATUS is a registered output; no combinational path from PULSE or ACK.
- Pulses shorter than one CLK period may be missed; this is permitted.

Optional Feature:
- Macro HPT_DEBOUNCE_EN.
- Defined: a debounce filter sits between sync2 and edge detect. The filtered level changes only after DEBOUNCE_CYCLES consecutive identical sync2 samples, which adds DEBOUNCE_CYCLES cycles of latency to EDGE. Glitches shorter than DEBOUNCE_CYCLES produce no EDGE.
- Undefined: no filter; EDGE is derived directly from sync2 with the latency given above.

Test Plan:
- Reset: PRESCALE=4, hold RESET 3 cycles with PULSE toggling -> PERIOD=0, STATUS=0x00 throughout and 1 cycle after release.
- Basic capture: PRESCALE=4, rising PULSE edges 40 CLK apart (2nd and 3rd edges) -> PERIOD=10, STATUS=0x09, VALID set 2 cycles after the PULSE edge.
- Handshake/overrun: capture, no ACK, next edge -> STATUS=0x0B; ACK 0->1 -> STATUS=0x08; ACK held high -> no further clear.
- Simultaneous: ACK rising edge in the same cycle as a capturing EDGE -> VALID=1, OVERRUN=0, new PERIOD loaded.
- Saturation/timeout: PRESCALE=2, edges 520 cycles apart -> PERIOD=255, SAT=1 (STATUS=0x0D). No edge for 600 cycles -> RUN=0, STATE IDLE; next edge produces no capture.
- HPT_DEBOUNCE_EN with DEBOUNCE_CYCLES=4: 3-cycle PULSE glitch -> no EDGE, STATUS unchanged. 10-cycle pulse -> EDGE 6 cycles after the PULSE rise.
